// File: rtl/tjmono_direct_pkg.sv
//==============================================================================
// Module      : tjmono_direct_pkg
// Description : Shared hit-word layout and link state encoding for the
//               TJ-Monopix2 direct readout transmitter and receiver.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tjmono_direct_pkg;

    // Hit word field widths
    localparam int COL_W = 6;
    localparam int ROW_W = 9;
    localparam int LE_W  = 6;
    localparam int TE_W  = 6;
    localparam int HIT_W = COL_W + ROW_W + LE_W + TE_W;

    // Serial order is MSB first: col, row, le, te
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [LE_W-1:0]  le;
        logic [TE_W-1:0]  te;
    } hit_word_t;

    // Serialiser states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // Assemble a hit word from its fields
    function automatic hit_word_t pack_hit(
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] row,
        input logic [LE_W-1:0]  le,
        input logic [TE_W-1:0]  te
    );
        hit_word_t w;
        w.col = col;
        w.row = row;
        w.le  = le;
        w.te  = te;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tjmono_direct_tx_fifo.sv
//==============================================================================
// Module      : tjmono_direct_tx_fifo
// Description : Synchronous hit-word FIFO with circular pointers one bit wider
//               than the address, so full/empty fall out of the MSB compare.
//               DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tjmono_direct_tx_fifo
    import tjmono_direct_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  hit_word_t                wr_data,
    input  logic                     pop,
    output hit_word_t                rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    hit_word_t   r_mem [DEPTH];

    // Pointer advance; reset empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign count   = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

`default_nettype wire

// File: rtl/tjmono_direct_tx.sv
//==============================================================================
// Module      : tjmono_direct_tx
// Description : Chip-side transmitter for the TJ-Monopix2 direct link.
//               Buffers hits, raises TOKEN while any are pending and on each
//               READ serialises one 27-bit hit MSB-first on DATA.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tjmono_direct_tx
    import tjmono_direct_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hit_valid,
    output logic                 hit_ready,
    input  logic [COL_W-1:0]     hit_col,
    input  logic [ROW_W-1:0]     hit_row,
    input  logic [LE_W-1:0]      hit_le,
    input  logic [TE_W-1:0]      hit_te,
    input  logic                 read,
    input  logic                 freeze,
    output logic                 token,
    output logic                 data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sent_cnt
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [4:0]  C_LAST  = 5'(HIT_W - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [HIT_W-1:0]   r_shift;
    logic [4:0]         r_bit_cnt;
    logic [CNT_WIDTH-1:0] r_sent_cnt;
    logic               r_hit_ready;
    logic               r_token;

    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_done;
    logic               w_busy;
    logic               w_data;
    hit_word_t          w_wr_data;
    hit_word_t          w_rd_data;
    logic [AW:0]        w_count;
    logic [AW:0]        w_count_next;
    logic               w_full;
    logic               w_empty;

    // The full check is redundant with READY but guards the buffer outright
    assign w_push    = hit_valid && r_hit_ready && !w_full;
    assign w_pop     = w_load;
    assign w_wr_data = pack_hit(hit_col, hit_row, hit_le, hit_te);

    tjmono_direct_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_wr_data),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_count_next = w_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    // READY and TOKEN look at the post-edge occupancy so they track the buffer
    // without a cycle of lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_ready <= 1'b0;
            r_token     <= 1'b0;
        end else begin
            r_hit_ready <= !freeze && (w_count_next < C_DEPTH);
            r_token     <= (w_count_next != '0);
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and outputs; a READ on the bit-0 cycle chains the next word
    // with no idle gap, any other READ during SHIFT is dropped
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b0;
        w_data       = 1'b0;
        case (r_state)
            IDLE: begin
                if (read && !w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                w_data = r_shift[HIT_W-1];
                if (r_bit_cnt == '0) begin
                    w_done = 1'b1;
                    if (read && !w_empty) begin
                        w_load       = 1'b1;
                        w_state_next = SHIFT;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Shift register and bit counter; counter holds the index of the bit on DATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= w_rd_data;
            r_bit_cnt <= C_LAST;
        end else if (w_busy && (r_bit_cnt != '0)) begin
            r_shift   <= {r_shift[HIT_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Count words that completed their bit-0 cycle; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_sent_cnt <= '0;
        else if (w_done) r_sent_cnt <= r_sent_cnt + 1'b1;
    end

    assign hit_ready = r_hit_ready;
    assign token     = r_token;
    assign data      = w_data;
    assign busy      = w_busy;
    assign sent_cnt  = r_sent_cnt;

endmodule

`default_nettype wire
